// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared FSM state type, LFSR width, default seed and request-size clamp for lfsr_sched.
package lfsr_pkg;
  typedef enum logic [1:0] {IDLE, GEN, RESP} state_t;
  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED_C = 5'b00001;
  function automatic int clamp_nbits(input int nb, input int maxb);
    return nb == 0 ? 1 : nb > maxb ? maxb : nb;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] k;
  // Scan from farthest to nearest so the nearest set index after ptr_i wins.
  always_comb begin
    idx_o = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(ptr_i) + i) % N);
      if (req_i[k]) idx_o = k;
    end
    any_o = |req_i;
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin scheduler sharing one Fibonacci LFSR between requesters, plus seed loads.
// Optional all-zero lockup recovery enabled by defining LFSR_LOCKUP_RECOVER_EN.
module lfsr_sched import lfsr_pkg::*; #(
  parameter int W = LFSR_W,
  parameter int NREQ = 4,
  parameter int MAXBITS = 16,
  parameter int CW = $clog2(MAXBITS + 1),
  parameter logic [W-1:0] DEFAULT_SEED = W'(DEFAULT_SEED_C),
  localparam int IW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_seed_valid,
  output logic                 cfg_seed_ready,
  input  logic [W-1:0]         cfg_seed,
  input  logic [W-1:0]         cfg_taps,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*CW-1:0]   req_nbits,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [MAXBITS-1:0]   rsp_data,
  output logic                 lfsr_reinit,
  output logic                 lfsr_advance,
  output logic [W-1:0]         lfsr_init_state,
  output logic [W-1:0]         lfsr_taps,
  input  logic                 lfsr_out,
  input  logic [W-1:0]         lfsr_state,
  output logic [7:0]           stat_lockups
);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, id_q, id_d, gidx;
  logic [CW-1:0] n_q, n_d, cnt_q, cnt_d, nb_raw, nb_clamp;
  logic [MAXBITS-1:0] data_q, data_d;
  logic [NREQ-1:0] gnt;
  logic gany, lockup, recover;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gidx),
    .any_o(gany)
  );

  assign nb_raw = req_nbits[gidx*CW +: CW];
  assign nb_clamp = CW'(clamp_nbits(int'(nb_raw), MAXBITS));
  assign lfsr_taps = cfg_taps;
  assign rsp_id = id_q;
  assign rsp_data = data_q;

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic [7:0] lock_q;
  assign lockup = lfsr_state == '0;
  assign stat_lockups = lock_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) lock_q <= '0;
    else if (recover && lock_q != 8'hFF) lock_q <= lock_q + 8'd1;
`else
  logic unused_state;
  assign unused_state = ^lfsr_state;
  assign lockup = 1'b0;
  assign stat_lockups = '0;
`endif

  // Seed loads outrank lockup recovery, which outranks requests; nothing fires while in reset.
  assign recover = state_q == IDLE && !rst && !cfg_seed_valid && lockup;

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    n_d = n_q;
    cnt_d = cnt_q;
    data_d = data_q;
    cfg_seed_ready = 1'b0;
    lfsr_reinit = 1'b0;
    lfsr_advance = 1'b0;
    req_ready = '0;
    rsp_valid = 1'b0;
    lfsr_init_state = recover ? DEFAULT_SEED : cfg_seed;
    unique case (state_q)
      IDLE: if (!rst) begin
        if (cfg_seed_valid) begin
          cfg_seed_ready = 1'b1;
          lfsr_reinit = 1'b1;
        end else if (recover) lfsr_reinit = 1'b1;
        else if (gany) begin
          req_ready = gnt;
          id_d = gidx;
          ptr_d = gidx;
          n_d = nb_clamp;
          cnt_d = '0;
          data_d = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        lfsr_advance = 1'b1;
        data_d = data_q | (MAXBITS'(lfsr_out) << cnt_q);
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == n_q) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(NREQ - 1);
      id_q <= '0;
      n_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
    end
endmodule

// File: tb/tb_lfsr_sched.sv
// tb_lfsr_sched: randomized and directed checks of lfsr_sched against a transaction-level model,
// with a behavioural 5-bit Fibonacci LFSR standing in for the shared lfsr instance.
module tb_lfsr_sched;
  localparam int NREQ = 4, CW = 5, MAXBITS = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic cfg_seed_valid = 1'b0, cfg_seed_ready, rsp_valid, rsp_ready = 1'b0;
  logic [4:0] cfg_seed = 5'b00101, cfg_taps = 5'b10100;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*CW-1:0] req_nbits = '0;
  logic [1:0] rsp_id;
  logic [15:0] rsp_data;
  logic lfsr_reinit, lfsr_advance;
  logic [4:0] lfsr_init_state, lfsr_taps, env = 5'b00001;
  logic [7:0] stat_lockups;
  logic zap = 1'b0;

  lfsr_sched dut (
    .clk(clk), .rst(rst),
    .cfg_seed_valid(cfg_seed_valid), .cfg_seed_ready(cfg_seed_ready), .cfg_seed(cfg_seed),
    .cfg_taps(cfg_taps), .req_valid(req_valid), .req_nbits(req_nbits), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .lfsr_reinit(lfsr_reinit), .lfsr_advance(lfsr_advance), .lfsr_init_state(lfsr_init_state),
    .lfsr_taps(lfsr_taps), .lfsr_out(env[0]), .lfsr_state(env), .stat_lockups(stat_lockups)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] step(input logic [4:0] s, input logic [4:0] t);
    return {s[3:0], ^(s & t)};
  endfunction

  always @(posedge clk)
    if (zap) env <= '0;
    else if (lfsr_reinit) env <= lfsr_init_state;
    else if (lfsr_advance) env <= step(env, lfsr_taps);

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [NREQ-1:0] rv = '0;
  int nb[NREQ];
  logic sv = 1'b0, rr = 1'b1, hold_all = 1'b0, busy = 1'b0;
  logic [4:0] seed = 5'b00101, mlfsr = 5'b00001;
  logic [15:0] mdata = '0, last_rsp = '0;
  int cyc = 0, rsp_at = 0, mptr = NREQ - 1, mid = 0, lock_m = 0;
  int adv_cnt = 0, seed_cyc = -1, g1_cyc = -1;
  int gq[$], gc[$];

  task automatic gen_bits(input int n, output logic [15:0] d);
    d = '0;
    for (int i = 0; i < n; i++) begin
      d[i] = mlfsr[0];
      mlfsr = step(mlfsr, cfg_taps);
    end
  endtask

  // One clock: drive inputs, predict every control output from the model, then advance.
  task automatic tick();
    logic [15:0] ed;
    logic [4:0] ei;
    logic [NREQ-1:0] erq;
    logic esr, eri, eadv, ev;
    int w, n;
    req_valid = rv;
    for (int k = 0; k < NREQ; k++) req_nbits[k*CW +: CW] = CW'(nb[k]);
    cfg_seed_valid = sv;
    cfg_seed = seed;
    rsp_ready = rr;
    #1;
    {esr, eri, eadv, ev} = '0;
    erq = '0;
    ei = seed;
    w = -1;
    if (!busy) begin
      if (sv) begin
        esr = 1'b1; eri = 1'b1; mlfsr = seed; sv = 1'b0;
      end
`ifdef LFSR_LOCKUP_RECOVER_EN
      else if (mlfsr == 5'b0) begin
        eri = 1'b1; ei = 5'b00001; mlfsr = 5'b00001;
        if (lock_m < 255) lock_m++;
      end
`endif
      else if (rv != 0) begin
        for (int i = 1; i <= NREQ; i++) if (w < 0 && rv[(mptr + i) % NREQ]) w = (mptr + i) % NREQ;
        erq[w] = 1'b1;
        n = nb[w] == 0 ? 1 : (nb[w] > MAXBITS ? MAXBITS : nb[w]);
        gen_bits(n, ed);
        mdata = ed; mid = w; mptr = w; busy = 1'b1; rsp_at = cyc + n + 1;
      end
    end else if (cyc < rsp_at) eadv = 1'b1;
    else begin
      ev = 1'b1;
      chk("rsp_id", 32'(rsp_id), 32'(mid));
      chk("rsp_data", 32'(rsp_data), 32'(mdata));
      if (rr) busy = 1'b0;
    end
    chk("ctl", 32'({cfg_seed_ready, req_ready, rsp_valid, lfsr_reinit, lfsr_advance, lfsr_init_state}),
        32'({esr, erq, ev, eri, eadv, ei}));
    for (int k = 0; k < NREQ; k++) if (req_ready[k]) begin gq.push_back(k); gc.push_back(cyc); end
    if (req_ready[1]) g1_cyc = cyc;
    if (cfg_seed_ready) seed_cyc = cyc;
    if (lfsr_advance) adv_cnt++;
    if (rsp_valid) last_rsp = rsp_data;
    if (w >= 0 && !hold_all) rv[w] = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || rv != 0 || sv) && t < 300) begin tick(); t++; end
    if (t >= 300) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  // Asynchronous reset landing mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_ctl", 32'({cfg_seed_ready, req_ready, rsp_valid, lfsr_reinit, lfsr_advance}), 32'd0);
    chk("rst_init", 32'(lfsr_init_state), 32'(cfg_seed));
    chk("rst_data", 32'({rsp_id, rsp_data}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    busy = 1'b0; mptr = NREQ - 1; rv = '0; sv = 1'b0; hold_all = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NREQ; k++) nb[k] = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ctl", 32'({cfg_seed_ready, req_ready, rsp_valid, lfsr_reinit, lfsr_advance}), 32'd0);
    chk("reset_data", 32'({rsp_id, rsp_data}), 32'd0);
    chk("reset_init", 32'(lfsr_init_state), 32'(cfg_seed));
    chk("reset_taps", 32'(lfsr_taps), 32'(cfg_taps));
    chk("reset_stat", 32'(stat_lockups), 32'd0);
    rst = 1'b0;
    // Seed 00001, taps 10100, five bits: 1,0,0,1,0 -> 5'b01001.
    sv = 1'b1; seed = 5'b00001;
    tick();
    rv[0] = 1'b1; nb[0] = 5;
    drain();
    chk("golden5", 32'(last_rsp), 32'd9);
    // Round robin after reset: all four held, two bits each.
    do_reset();
    gq.delete(); gc.delete();
    for (int k = 0; k < NREQ; k++) nb[k] = 2;
    rv = 4'b1111; hold_all = 1'b1; rr = 1'b1;
    for (int t = 0; t < 60 && gq.size() < 5; t++) tick();
    hold_all = 1'b0; rv = '0;
    drain();
    chk("rr_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", 32'(gq[i]), 32'(i % NREQ));
    for (int i = 1; i < 5 && i < gc.size(); i++) chk("rr_spacing", 32'(gc[i] - gc[i-1]), 32'd4);
    // Backpressure with other requests waiting.
    rr = 1'b0; rv[2] = 1'b1; nb[2] = 3;
    for (int t = 0; t < 20 && !(busy && cyc >= rsp_at); t++) tick();
    rv = 4'b0011; nb[0] = 1; nb[1] = 1;
    repeat (10) tick();
    rr = 1'b1;
    drain();
    // Clamp boundaries.
    adv_cnt = 0; rv[3] = 1'b1; nb[3] = 0;
    drain();
    chk("adv_nb0", 32'(adv_cnt), 32'd1);
    chk("nb0_upper", 32'(last_rsp[15:1]), 32'd0);
    adv_cnt = 0; rv[3] = 1'b1; nb[3] = 31;
    drain();
    chk("adv_nb31", 32'(adv_cnt), 32'd16);
    // Seed request collides with GEN while requester 1 waits.
    g1_cyc = -1; seed_cyc = -1;
    rv[0] = 1'b1; nb[0] = 4;
    tick(); tick();
    sv = 1'b1; seed = 5'b10110; rv[1] = 1'b1; nb[1] = 2;
    drain();
    chk("seed_then_req1", 32'(g1_cyc - seed_cyc), 32'd1);
    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < NREQ; k++)
        if (!rv[k] && $urandom_range(0, 3) == 0) begin rv[k] = 1'b1; nb[k] = $urandom_range(0, 31); end
      if (!sv && $urandom_range(0, 24) == 0) begin sv = 1'b1; seed = 5'($urandom_range(1, 31)); end
      rr = $urandom_range(0, 3) != 0;
      tick();
    end
    rr = 1'b1;
    drain();
    // Reset three cycles into an eight-bit GEN: no response may follow.
    rv[0] = 1'b1; nb[0] = 8;
    tick();
    repeat (3) tick();
    adv_cnt = 0;
    do_reset();
    sv = 1'b1; seed = 5'b01101;
    repeat (12) tick();
    chk("no_rsp_after_rst", 32'(adv_cnt), 32'd0);
`ifdef LFSR_LOCKUP_RECOVER_EN
    zap = 1'b1;
    tick();
    zap = 1'b0; mlfsr = 5'b0;
    tick();
    tick();
`endif
    chk("stat_lockups", 32'(stat_lockups), 32'(lock_m));
    rv[2] = 1'b1; nb[2] = 6;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lfsr_sched.md
Name: lfsr_sched

Overview:
- Shares one 5-bit Fibonacci LFSR (lfsr instance, controlled through its reinit/advance/initial_state/taps pins) between NREQ requesters.
- Each requester asks for 1..MAXBITS pseudo-random bits. The scheduler grants round-robin, steps the LFSR once per bit, collects the serial output into a word and returns it on a shared response channel tagged with the requester id.
- Also sequences seed (re)loads from the configuration side.

Parameters:
- W, 5, LFSR state width (matches lfsr instance)
- NREQ, 4, number of requesters
- MAXBITS, 16, max bits per request / response data width
- CW, $clog2(MAXBITS+1), width of per-request bit count
- DEFAULT_SEED, 5'b00001, seed used by lockup recovery (optional feature)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- cfg_seed_valid  in  1  seed load request
- cfg_seed_ready  out  1  seed accepted this cycle
- cfg_seed  in  W  seed value
- cfg_taps  in  W  tap mask, static during operation
- req_valid  in  NREQ  per-requester request
- req_nbits  in  NREQ*CW  packed bit counts, requester i at [i*CW +: CW]
- req_ready  out  NREQ  one-hot accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  $clog2(NREQ)  requester index of response
- rsp_data  out  MAXBITS  collected bits, right-aligned
- lfsr_reinit  out  1  to lfsr.reinit
- lfsr_advance  out  1  to lfsr.advance
- lfsr_init_state  out  W  to lfsr.initial_state
- lfsr_taps  out  W  to lfsr.taps (= cfg_taps)
- lfsr_out  in  1  from lfsr.out (state bit 0)
- lfsr_state  in  W  from lfsr.out_state
- stat_lockups  out  8  saturating lockup-recovery count

Behaviour:
- Reset (async, immediate):
  - FSM=IDLE; rr pointer = NREQ-1, so requester 0 wins first.
  - All outputs 0 except lfsr_taps (passthrough) and lfsr_init_state (= cfg_seed).
- FSM states:
  - IDLE:
    - cfg_seed_valid has priority: cfg_seed_ready=1, lfsr_reinit=1 for that one cycle, stay IDLE.
    - Else if any req_valid: req_ready[g]=1 same cycle for round-robin winner g (first set index after pointer, wrapping); latch id=g, n=clamp(req_nbits[g]), clear data/count, pointer<=g; go GEN.
  - GEN:
    - lfsr_advance=1 every cycle.
    - rsp_data[count] <= lfsr_out (bit 0 of state before the step); count++.
    - After n GEN cycles go RESP.
  - RESP:
    - rsp_valid=1, rsp_id/rsp_data held stable until rsp_ready=1 sampled; then go IDLE.
    - rsp_valid drops next cycle.
- Clamp rule: nbits=0 treated as 1; nbits>MAXBITS treated as MAXBITS. Unused upper rsp_data bits are 0.
- Latency: request accepted cycle T → GEN T+1..T+n → rsp_valid first high T+n+1.
  - Minimum request-to-request spacing is n+2 cycles with rsp_ready tied high.
- lfsr_reinit and lfsr_advance never assert in the same cycle; neither asserts in RESP.
- Seed request during GEN/RESP: cfg_seed_ready stays 0 (held off) until next IDLE cycle. Seed always beats pending requests there.
- Requester dropping req_valid before grant: no effect. Deasserting after grant is not required (one transaction per req_ready pulse).
- At most one req_ready bit high per cycle; none while cfg_seed_ready=1.
- Reset mid-GEN/RESP: transaction discarded, no response.

Optional Feature:
- Macro LFSR_LOCKUP_RECOVER_EN.
- Defined:
  - In IDLE with no cfg_seed_valid, if lfsr_state==0 (all-zero lockup), issue lfsr_reinit for one cycle with lfsr_init_state=DEFAULT_SEED and increment stat_lockups (saturate at 255).
  - This takes priority over requests, below cfg seed loads.
- Undefined: no check; stat_lockups tied 0; lfsr_init_state always = cfg_seed.

Decomposition:
- Package lfsr_pkg: FSM state enum (IDLE, GEN, RESP), LFSR_W=5 constant, default seed constant.
- One sub-module: rr_arbiter (NREQ-wide round-robin, req vector + pointer in, one-hot grant + index out, combinational).

Test Plan:
- Seed then single request: cfg_seed=5'b00001, taps=5'b10100, req0 nbits=5 → lfsr_reinit one cycle; 5 advance cycles; rsp_valid at T+6, rsp_id=0, rsp_data equals the first 5 bits of a golden Fibonacci model.
- Round-robin fairness: req_valid=4'b1111 held, nbits=2, rsp_ready=1 → grants in order 0,1,2,3,0; each spaced 4 cycles.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid/rsp_data/rsp_id stable, no advance, no req_ready; rsp_ready=1 → IDLE next cycle.
- Clamp/boundary: nbits=0 → one advance, rsp_data[15:1]=0; nbits=31 → exactly 16 advances.
- Seed collision: cfg_seed_valid raised during GEN with req1 pending → cfg_seed_ready only at first IDLE cycle, then req1 granted the following cycle.
- Async reset mid-GEN after 3 advances → outputs 0 immediately, no rsp_valid. With LFSR_LOCKUP_RECOVER_EN, force lfsr_state=0 → reinit with 5'b00001, stat_lockups=1.
